// File: rtl/ahead_adder_pkg.sv
// Shared constants for the two-level carry-lookahead adder.
// Group width, default operand width and the group-count helper live here.
package ahead_adder_pkg;

    localparam int unsigned GROUP_W       = 4;
    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned num_groups(input int unsigned width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/ahead_adder_cla4.sv
// One 4-bit lookahead group: sum bits plus group generate/propagate.
// Every internal carry is a flat sum-of-products of g, p and ci.
module cla4
    import ahead_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       G,
    output logic       P
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;
    end

    always_comb begin
        c    = '0;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    end

    // G and P depend only on a and b, so the group's carry-in never feeds them.
    always_comb begin
        s = p ^ c;
        G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        P = &p;
    end

endmodule

// File: rtl/ahead_adder.sv
// Registered WIDTH-bit carry-lookahead adder built from cla4 groups and a flat
// second-level carry unit. Define AHEAD_ADDER_OVF_EN to add the signed overflow output.
module ahead_adder
    import ahead_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic [WIDTH-1:0] f,
`ifdef AHEAD_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             c8
);

    localparam int unsigned NUM_GROUPS = num_groups(WIDTH);

    if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
        $error("ahead_adder: WIDTH must be a non-zero multiple of 4");
    end

    logic [NUM_GROUPS-1:0] grp_g;
    logic [NUM_GROUPS-1:0] grp_p;
    logic [NUM_GROUPS:0]   grp_c;
    logic [WIDTH-1:0]      sum;

    // Carry into group k as an unrolled OR of AND terms; no group waits on another.
    function automatic logic group_carry(input logic [NUM_GROUPS-1:0] gg,
                                         input logic [NUM_GROUPS-1:0] pp,
                                         input logic                  cin,
                                         input int                    k);
        logic acc;
        logic term;
        acc = cin;
        for (int i = 0; i < int'(NUM_GROUPS); i++) begin
            if (i < k) acc = acc & pp[i];
        end
        for (int j = 0; j < int'(NUM_GROUPS); j++) begin
            if (j < k) begin
                term = gg[j];
                for (int i = 0; i < int'(NUM_GROUPS); i++) begin
                    if (i > j && i < k) term = term & pp[i];
                end
                acc = acc | term;
            end
        end
        return acc;
    endfunction

    always_comb begin
        grp_c = '0;
        for (int k = 0; k <= int'(NUM_GROUPS); k++) begin
            grp_c[k] = group_carry(grp_g, grp_p, c0, k);
        end
    end

    for (genvar gi = 0; gi < int'(NUM_GROUPS); gi++) begin : g_grp
        cla4 u_cla4 (
            .a  (a[gi*GROUP_W +: GROUP_W]),
            .b  (b[gi*GROUP_W +: GROUP_W]),
            .ci (grp_c[gi]),
            .s  (sum[gi*GROUP_W +: GROUP_W]),
            .G  (grp_g[gi]),
            .P  (grp_p[gi])
        );
    end

    logic [WIDTH-1:0] f_d, f_q;
    logic             c8_d, c8_q;

    always_comb begin
        f_d  = sum;
        c8_d = grp_c[NUM_GROUPS];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q  <= '0;
            c8_q <= 1'b0;
        end else begin
            f_q  <= f_d;
            c8_q <= c8_d;
        end
    end

    assign f  = f_q;
    assign c8 = c8_q;

`ifdef AHEAD_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // Carry into the MSB is recovered from its sum bit: s = p ^ c.
    always_comb begin
        ovf_d = (sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1]) ^ grp_c[NUM_GROUPS];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ahead_adder.sv
// Self-checking bench for ahead_adder (WIDTH=8): directed table, reset sequences,
// random back-to-back vectors against an arithmetic model; ovf checks when enabled.
module tb_ahead_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c0;
    logic [W-1:0] f;
    logic         c8;
`ifdef AHEAD_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks;
    int errors;

    ahead_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c0    (c0),
        .f     (f),
`ifdef AHEAD_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .c8    (c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c0;
        logic [W-1:0] exp_f;
        logic         exp_c8;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic cycle(input logic rst, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc);
        @(negedge clk);
        rst_n = rst;
        a     = va;
        b     = vb;
        c0    = vc;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic, signed range test for overflow.
    task automatic model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         output logic [W-1:0] mf, output logic mc, output logic mo);
        int us;
        int ss;
        us = int'(va) + int'(vb) + int'(vc);
        ss = int'($signed(va)) + int'($signed(vb)) + int'(vc);
        mf = us[W-1:0];
        mc = (us >= (1 << W));
        mo = (ss > 127) || (ss < -128);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] ef, input logic ec,
                              input logic eo);
        check({name, ".f"}, 32'(f), 32'(ef));
        check({name, ".c8"}, 32'(c8), 32'(ec));
`ifdef AHEAD_ADDER_OVF_EN
        check({name, ".ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo) begin end
`endif
    endtask

    vec_t tbl[7];

    initial begin
        logic [W-1:0] mf;
        logic         mc;
        logic         mo;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = '1;
        b      = '1;
        c0     = 1'b1;

        tbl[0] = '{8'h11, 8'h11, 1'b0, 8'h22, 1'b0};
        tbl[1] = '{8'h77, 8'h77, 1'b0, 8'hEE, 1'b0};
        tbl[2] = '{8'h33, 8'hCC, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        tbl[4] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[6] = '{8'hF3, 8'h3F, 1'b1, 8'h33, 1'b1};

        // Reset held for two cycles with all-ones inputs.
        cycle(1'b0, 8'hFF, 8'hFF, 1'b1);
        expect_out("reset0", 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'hFF, 8'hFF, 1'b1);
        expect_out("reset1", 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 8'hFF, 1'b1);
        expect_out("release", 8'hFF, 1'b1, 1'b0);

        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].c0);
            model(tbl[i].a, tbl[i].b, tbl[i].c0, mf, mc, mo);
            expect_out($sformatf("table%0d", i), tbl[i].exp_f, tbl[i].exp_c8, mo);
        end

        // Mid-stream reset discards the in-flight result; first post-reset result is fresh.
        cycle(1'b1, 8'h80, 8'h81, 1'b0);
        expect_out("pre_mid_reset", 8'h01, 1'b1, 1'b1);
        cycle(1'b0, 8'hF0, 8'h0F, 1'b1);
        expect_out("mid_reset", 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 8'h34, 1'b1);
        expect_out("post_mid_reset", 8'h47, 1'b0, 1'b0);

`ifdef AHEAD_ADDER_OVF_EN
        cycle(1'b1, 8'h7F, 8'h01, 1'b0);
        check("ovf_pos.ovf", 32'(ovf), 32'd1);
        check("ovf_pos.f", 32'(f), 32'h80);
        cycle(1'b1, 8'h80, 8'h80, 1'b0);
        expect_out("ovf_neg", 8'h00, 1'b1, 1'b1);
`endif

        // Random vectors, new operands every cycle.
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            cycle(1'b1, ra, rb, rc);
            model(ra, rb, rc, mf, mc, mo);
            expect_out($sformatf("rand%0d", n), mf, mc, mo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
